// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: registered writeback stage with load wait and result-source select.
// Optional WB_FWD_EN adds a one-cycle delayed copy of the write port for decode bypass.
module wb_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wr,
    input  logic              in_load,
    input  logic              in_regdst,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [2:0]        in_sel,
    input  logic [1:0]        in_cmp_op,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_ofl,
    input  logic              in_zero,
    input  logic              in_pos,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_data,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_reg,
    output logic [DATA_W-1:0] wr_data,
    output logic              retire
`ifdef WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;
    state_t state;
    logic ld_wr, cond, cap;
    logic [DATA_W-1:0] mem_q, btr, cap_data;
    assign in_ready = (state != WAIT_MEM);
    assign cap = in_valid & in_ready;
    always_comb begin
        cond = in_cmp_op == 2'd0 ? in_zero :
               in_cmp_op == 2'd1 ? in_pos :
               in_cmp_op == 2'd2 ? (in_pos | in_zero) : in_ofl;
        for (int i = 0; i < DATA_W; i++) btr[i] = in_alu[DATA_W-1-i];
        cap_data = in_sel == 3'd1 ? mem_q :
                   in_sel == 3'd2 ? (in_alu | in_imm) :
                   in_sel == 3'd3 ? {{(DATA_W-1){1'b0}}, cond} :
                   in_sel == 3'd4 ? btr :
                   in_sel == 3'd5 ? in_imm : in_alu;
    end
    // Non-load results are resolved at capture; loads keep only their write flag and index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_en   <= 1'b0;
            retire  <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
            ld_wr   <= 1'b0;
            mem_q   <= '0;
        end else begin
            wr_en  <= 1'b0;
            retire <= 1'b0;
            if (state == WAIT_MEM) begin
                if (mem_done) begin
                    state   <= WRITE;
                    mem_q   <= mem_data;
                    wr_data <= mem_data;
                    wr_en   <= ld_wr;
                    retire  <= 1'b1;
                end
            end else if (cap) begin
                wr_reg <= in_regdst ? in_rd : in_rs;
                if (in_load) begin
                    state <= WAIT_MEM;
                    ld_wr <= in_wr;
                end else begin
                    state   <= WRITE;
                    wr_data <= cap_data;
                    wr_en   <= in_wr;
                    retire  <= 1'b1;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
`ifdef WB_FWD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid <= 1'b0;
            fwd_reg   <= '0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= wr_en;
            fwd_reg   <= wr_reg;
            fwd_data  <= wr_data;
        end
    end
`endif
endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb_wb_stage_pipe: directed and random checks of wb_stage_pipe against a transaction-level model.
module tb_wb_stage_pipe;
    logic clk = 0, rst = 1;
    logic in_valid = 0, in_ready, in_wr = 0, in_load = 0, in_regdst = 0;
    logic [2:0] in_rd = 0, in_rs = 0, in_sel = 0;
    logic [1:0] in_cmp_op = 0;
    logic [15:0] in_alu = 0, in_imm = 0, mem_data = 0, wr_data;
    logic in_ofl = 0, in_zero = 0, in_pos = 0, mem_done = 0;
    logic wr_en, retire;
    logic [2:0] wr_reg;
`ifdef WB_FWD_EN
    logic fwd_valid;
    logic [2:0] fwd_reg;
    logic [15:0] fwd_data;
`endif
    int n_assert = 0, n_fail = 0;
    logic m_wait = 0, m_ld_wr = 0, e_en = 0, e_ret = 0, f_v = 0;
    logic [2:0] m_ld_reg = 0, e_reg = 0, f_r = 0;
    logic [15:0] m_mem = 0, e_data = 0, f_d = 0;

    wb_stage_pipe #(.DATA_W(16), .REG_AW(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_wr(in_wr),
        .in_load(in_load), .in_regdst(in_regdst), .in_rd(in_rd), .in_rs(in_rs),
        .in_sel(in_sel), .in_cmp_op(in_cmp_op), .in_alu(in_alu), .in_imm(in_imm),
        .in_ofl(in_ofl), .in_zero(in_zero), .in_pos(in_pos), .mem_done(mem_done),
        .mem_data(mem_data), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .retire(retire)
`ifdef WB_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_data(input logic [2:0] sel, input logic [1:0] op,
                                             input logic [15:0] alu, imm, mem,
                                             input logic ofl, zero, pos);
        logic [15:0] r;
        case (sel)
            3'd1: return mem;
            3'd2: return alu | imm;
            3'd3: case (op)
                      2'd0: return zero ? 16'd1 : 16'd0;
                      2'd1: return pos ? 16'd1 : 16'd0;
                      2'd2: return (pos || zero) ? 16'd1 : 16'd0;
                      default: return ofl ? 16'd1 : 16'd0;
                  endcase
            3'd4: begin
                r = 0;
                for (int k = 0; k < 16; k++) if (alu[k]) r = r + (16'd1 << (15 - k));
                return r;
            end
            3'd5: return imm;
            default: return alu;
        endcase
    endfunction

    task automatic step();
        logic r, chk_d;
        r = rst;
        if (!r) chk("in_ready", 32'(in_ready), 32'(!m_wait));
        if (r) begin
            m_wait = 0; m_mem = 0; e_en = 0; e_ret = 0; e_reg = 0; e_data = 0;
            f_v = 0; f_r = 0; f_d = 0; chk_d = 1;
        end else begin
            f_v = e_en; f_r = e_reg; f_d = e_data; chk_d = 0;
            e_en = 0; e_ret = 0;
            if (m_wait) begin
                if (mem_done) begin
                    m_wait = 0; m_mem = mem_data;
                    e_en = m_ld_wr; e_ret = 1; e_reg = m_ld_reg; e_data = mem_data;
                end
            end else if (in_valid) begin
                e_reg = in_regdst ? in_rd : in_rs;
                if (in_load) begin
                    m_wait = 1; m_ld_wr = in_wr; m_ld_reg = e_reg;
                end else begin
                    e_en = in_wr; e_ret = 1;
                    e_data = ref_data(in_sel, in_cmp_op, in_alu, in_imm, m_mem, in_ofl, in_zero, in_pos);
                end
            end
        end
        chk_d = chk_d | e_en;
        @(posedge clk);
        #1;
        chk("wr_en", 32'(wr_en), 32'(e_en));
        chk("retire", 32'(retire), 32'(e_ret));
        if (chk_d) begin
            chk("wr_reg", 32'(wr_reg), 32'(e_reg));
            chk("wr_data", 32'(wr_data), 32'(e_data));
        end
`ifdef WB_FWD_EN
        chk("fwd_valid", 32'(fwd_valid), 32'(f_v));
        if (r || f_v) begin
            chk("fwd_reg", 32'(fwd_reg), 32'(f_r));
            chk("fwd_data", 32'(fwd_data), 32'(f_d));
        end
`endif
    endtask

    task automatic issue(input logic wr, ld, rdst, input logic [2:0] rd, rs, sel,
                         input logic [1:0] op, input logic [15:0] alu, imm,
                         input logic ofl, zero, pos);
        in_valid = 1; in_wr = wr; in_load = ld; in_regdst = rdst; in_rd = rd; in_rs = rs;
        in_sel = sel; in_cmp_op = op; in_alu = alu; in_imm = imm;
        in_ofl = ofl; in_zero = zero; in_pos = pos;
        step();
        in_valid = 0;
    endtask

    initial begin
        rst = 1;
        step(); step();
        rst = 0;
        step();
        issue(1, 0, 1, 3'd1, 3'd0, 3'd0, 2'd0, 16'h0001, 16'h0, 0, 0, 0);
        issue(1, 0, 1, 3'd2, 3'd0, 3'd0, 2'd0, 16'h0002, 16'h0, 0, 0, 0);
        issue(1, 0, 1, 3'd3, 3'd0, 3'd0, 2'd0, 16'h0003, 16'h0, 0, 0, 0);
        step();
        issue(1, 1, 0, 3'd0, 3'd5, 3'd1, 2'd0, 16'h0, 16'h0, 0, 0, 0);
        mem_data = 16'h1111;
        step(); step(); step();
        mem_done = 1; mem_data = 16'hBEEF;
        step();
        mem_done = 0;
        step();
        chk("load_data", 32'(m_mem), 32'h0000BEEF);
        issue(1, 0, 1, 3'd4, 3'd0, 3'd2, 2'd0, 16'h1200, 16'h0034, 0, 0, 0);
        issue(1, 0, 1, 3'd4, 3'd0, 3'd4, 2'd0, 16'h0001, 16'h0, 0, 0, 0);
        issue(1, 0, 1, 3'd4, 3'd0, 3'd3, 2'd2, 16'h0, 16'h0, 0, 1, 0);
        issue(1, 0, 1, 3'd4, 3'd0, 3'd3, 2'd3, 16'h0, 16'h0, 0, 1, 1);
        issue(1, 0, 1, 3'd4, 3'd0, 3'd5, 2'd0, 16'h0, 16'hFFF0, 0, 0, 0);
        step();
        issue(1, 1, 0, 3'd0, 3'd6, 3'd1, 2'd0, 16'h0, 16'h0, 0, 0, 0);
        step();
        rst = 1;
        step();
        rst = 0; mem_done = 1; mem_data = 16'hDEAD;
        step();
        mem_done = 0;
        step();
        issue(0, 0, 0, 3'd0, 3'd2, 3'd0, 2'd0, 16'h5555, 16'h0, 0, 0, 0);
        step();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            in_valid = $urandom_range(0, 3) != 0;
            in_wr = $urandom_range(0, 3) != 0;
            in_load = $urandom_range(0, 3) == 0;
            in_regdst = 1'($urandom);
            in_rd = 3'($urandom);
            in_rs = 3'($urandom);
            in_sel = 3'($urandom);
            in_cmp_op = 2'($urandom);
            in_alu = 16'($urandom);
            in_imm = 16'($urandom);
            in_ofl = 1'($urandom);
            in_zero = 1'($urandom);
            in_pos = 1'($urandom);
            mem_done = $urandom_range(0, 2) == 0;
            mem_data = 16'($urandom);
            step();
        end
        rst = 0; in_valid = 0; mem_done = 0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
